// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word memory with byte/halfword lanes, optional wait states,
// two-cycle ERROR response and write-to-read forwarding on back-to-back accesses.
module ahb_sram_slave #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES - 1);
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_hreadyout;
    logic          r_hresp;
    logic          w_hreadyout_nxt;
    logic          w_hresp_nxt;
    logic [31:0]   r_hrdata;
    logic          r_pend;
    logic          r_write;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_lanes;
    logic [3:0]    r_cnt;

    logic          w_accept;
    logic          w_illegal;
    logic          w_accept_ok;
    logic          w_accept_err;
    logic          w_complete;
    logic          w_wr_commit;
    logic          w_rd_load;
    logic [3:0]    w_lanes;
    logic [AW-1:0] w_a_word;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_old;
    logic [31:0]   w_merged;
    logic [31:0]   w_rd_data;
    logic          w_unused;

    assign w_unused     = HTRANS[0];
    assign w_a_word     = HADDR[AW+1:2];
    assign w_accept     = HSEL & HTRANS[1] & HREADY & r_hreadyout;
    assign w_illegal    = (|HADDR[31:AW+2]) | (HSIZE > 3'd2)
                        | ((HSIZE == 3'd1) & HADDR[0])
                        | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign w_accept_ok  = w_accept & ~w_illegal;
    assign w_accept_err = w_accept & w_illegal;

    // A pending OKAY transfer finishes on any edge where HREADYOUT is high
    assign w_complete   = r_pend & r_hreadyout;
    assign w_wr_commit  = w_complete & r_write;
    assign w_rd_load    = (w_accept_ok & ~HWRITE & ZERO_WAIT)
                        | ((r_state == S_WAIT) & (r_cnt == 4'd0) & ~r_write);
    assign w_rd_idx     = ZERO_WAIT ? w_a_word : r_addr;
    assign w_rd_data    = (w_wr_commit && (r_addr == w_rd_idx)) ? w_merged : r_mem[w_rd_idx];

    always_comb begin
        w_lanes = 4'b1111;
        case (HSIZE)
            3'd0:    w_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: ;
        endcase
    end

    always_comb begin
        w_old    = r_mem[r_addr];
        w_merged = w_old;
        for (int b = 0; b < 4; b++) begin
            if (r_lanes[b]) w_merged[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    // State register with registered bus responses
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hreadyout <= w_hreadyout_nxt;
            r_hresp     <= w_hresp_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
            S_ERR1: w_state_nxt = S_ERR2;
            default: begin
                w_state_nxt = S_IDLE;
                if (w_accept_err)                  w_state_nxt = S_ERR1;
                else if (w_accept_ok && !ZERO_WAIT) w_state_nxt = S_WAIT;
            end
        endcase
    end

    always_comb begin
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = 1'b0;
        case (w_state_nxt)
            S_WAIT: w_hreadyout_nxt = 1'b0;
            S_ERR1: begin
                w_hreadyout_nxt = 1'b0;
                w_hresp_nxt     = 1'b1;
            end
            S_ERR2: w_hresp_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_lanes  <= '0;
            r_cnt    <= '0;
            r_hrdata <= '0;
        end else begin
            if (w_accept_ok) begin
                r_pend  <= 1'b1;
                r_write <= HWRITE;
                r_addr  <= w_a_word;
                r_lanes <= w_lanes;
                r_cnt   <= WS_LOAD;
            end else begin
                if (w_complete) r_pend <= 1'b0;
                if ((r_state == S_WAIT) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
            end
            if (w_rd_load) r_hrdata <= w_rd_data;
        end
    end

    // Memory survives reset; a write caught by reset is dropped
    always_ff @(posedge clk) begin
        if (rst && w_wr_commit) r_mem[r_addr] <= w_merged;
    end

    assign HRDATA    = r_hrdata;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance driven by a
// pipelined AHB master, checked against a transaction-level memory model.
module tb_ahb_sram_slave;

    localparam int unsigned DEPTH = 256;

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [31:0] wdata;
        bit        err;
        bit        chk;
        bit [31:0] rdata;
    } tx_t;

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [31:0] wdata;
        bit        exp_err;
        bit [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]       hsel;
    logic [1:0]       hwrite;
    logic [1:0][1:0]  htrans;
    logic [1:0][2:0]  hsize;
    logic [1:0][31:0] haddr;
    logic [1:0][31:0] hwdata;
    logic [1:0][31:0] hrdata;
    logic [1:0]       hreadyout;
    logic [1:0]       hresp;

    int n_cmp = 0;
    int n_bad = 0;
    bit [31:0] mdl [2][DEPTH];
    tx_t  txq[$];
    vec_t vecs[22];

    always #5 clk = ~clk;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, legality from address/size arithmetic
    task automatic add_tx(input int d, input bit wr, input bit [31:0] a,
                          input bit [2:0] sz, input bit [31:0] wd);
        tx_t t;
        int  nbytes;
        int  w;
        int  off;
        t.wr = wr; t.addr = a; t.size = sz; t.wdata = wd; t.rdata = '0;
        t.err = (a >= 4 * DEPTH) || (sz > 3'd2);
        nbytes = 1 << sz;
        if (!t.err && ((a % nbytes) != 0)) t.err = 1'b1;
        t.chk = !wr && !t.err;
        if (!t.err) begin
            w   = int'(a >> 2);
            off = int'(a % 4);
            if (wr) begin
                for (int b = off; b < off + nbytes; b++) mdl[d][w][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                t.rdata = mdl[d][w];
            end
        end
        txq.push_back(t);
    endtask

    task automatic drive_addr(input int d, input tx_t t);
        hsel[d]   = 1'b1;
        htrans[d] = {1'b1, 1'($urandom_range(0, 1))};
        haddr[d]  = t.addr;
        hwrite[d] = t.wr;
        hsize[d]  = t.size;
    endtask

    task automatic drive_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
    endtask

    // Issue the queue back-to-back and check each data phase as it completes
    task automatic run_seq(input int d);
        int n;
        int ws;
        int waits;
        n  = txq.size();
        ws = (d == 0) ? 0 : 3;
        if (n == 0) return;
        drive_addr(d, txq[0]);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            hwdata[d] = txq[i].wdata;
            if (i + 1 < n) drive_addr(d, txq[i+1]);
            else           drive_idle(d);
            waits = 0;
            @(negedge clk);
            while (hreadyout[d] !== 1'b1 && waits < 40) begin
                waits++;
                @(negedge clk);
            end
            chk($sformatf("d%0d tx%0d waits", d, i), 32'(waits), txq[i].err ? 32'd1 : 32'(ws));
            chk($sformatf("d%0d tx%0d hresp", d, i), 32'(hresp[d]), 32'(txq[i].err));
            if (txq[i].chk)
                chk($sformatf("d%0d tx%0d @%h hrdata", d, i, txq[i].addr), hrdata[d], txq[i].rdata);
            @(posedge clk); #1;
        end
        txq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h000, 3'd2, 32'h00500093, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h000, 3'd2, 32'h0,        1'b0, 32'h00500093};
        vecs[2]  = '{1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h010, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 32'h010, 3'd2, 32'h11223344, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h013, 3'd0, 32'hAA000000, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h010, 3'd2, 32'h0,        1'b0, 32'hAA223344};
        vecs[7]  = '{1'b1, 32'h012, 3'd1, 32'hBEEF0000, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h010, 3'd2, 32'h0,        1'b0, 32'hBEEF3344};
        vecs[9]  = '{1'b0, 32'h400, 3'd2, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h006, 3'd2, 32'h0,        1'b1, 32'h0};
        vecs[11] = '{1'b1, 32'h011, 3'd1, 32'h12345678, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 32'h410, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 32'h012, 3'd3, 32'h0,        1'b1, 32'h0};
        vecs[14] = '{1'b0, 32'h010, 3'd0, 32'h0,        1'b0, 32'hBEEF3344};
        vecs[15] = '{1'b1, 32'h020, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 32'h020, 3'd2, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[17] = '{1'b1, 32'h021, 3'd0, 32'h00007700, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 32'h020, 3'd2, 32'h0,        1'b0, 32'hCAFE770D};
        vecs[19] = '{1'b1, 32'h3FC, 3'd2, 32'h55AA1234, 1'b0, 32'h0};
        vecs[20] = '{1'b0, 32'h3FC, 3'd1, 32'h0,        1'b0, 32'h55AA1234};
        vecs[21] = '{1'b0, 32'h3FE, 3'd1, 32'h0,        1'b0, 32'h55AA1234};

        rst    = 1'b0;
        hsel   = '0;
        hwrite = '0;
        htrans = '0;
        hsize  = '0;
        haddr  = '0;
        hwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset hreadyout", d), 32'(hreadyout[d]), 32'd1);
            chk($sformatf("d%0d reset hresp", d),     32'(hresp[d]),     32'd0);
            chk($sformatf("d%0d reset hrdata", d),    hrdata[d],         32'd0);
        end
        @(posedge clk); #1;

        // Give every word a known value
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < int'(DEPTH); w++) add_tx(d, 1'b1, 32'(w * 4), 3'd2, $urandom);
            run_seq(d);
        end

        // Directed vectors with hand-derived expectations
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 22; i++) begin
                add_tx(d, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata);
                txq[txq.size()-1].err   = vecs[i].exp_err;
                txq[txq.size()-1].chk   = !vecs[i].wr && !vecs[i].exp_err;
                txq[txq.size()-1].rdata = vecs[i].exp_rdata;
            end
            run_seq(d);
        end

        // Reset in the second wait cycle of a three-wait write drops the write
        haddr[1]  = 32'h30;
        hwrite[1] = 1'b1;
        hsize[1]  = 3'd2;
        htrans[1] = 2'b10;
        hsel[1]   = 1'b1;
        @(posedge clk); #1;
        drive_idle(1);
        hwdata[1] = ~mdl[1][12];
        @(negedge clk);
        chk("rst-mid-wait cycle1 hreadyout", 32'(hreadyout[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst-mid-wait hreadyout", 32'(hreadyout[1]), 32'd1);
        chk("rst-mid-wait hresp",     32'(hresp[1]),     32'd0);
        chk("rst-mid-wait hrdata",    hrdata[1],         32'd0);
        @(posedge clk); #1;
        add_tx(1, 1'b0, 32'h30, 3'd2, 32'h0);
        run_seq(1);

        // Random traffic concentrated on few words to hit forwarding and errors
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 120; r++) begin
                bit        wr;
                bit [31:0] a;
                bit [2:0]  sz;
                int        sel;
                wr  = 1'($urandom_range(0, 1));
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      a = $urandom_range(32'h400, 32'hFFFF);
                else if (sel == 1) a = 32'h3F0 + $urandom_range(0, 15);
                else               a = $urandom_range(0, 31);
                sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                add_tx(d, wr, a, sz, $urandom);
            end
            run_seq(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
